// File: rtl/nios_system_key_in_pkg.sv
// Shared register map, edge-type codes and edge qualification helper for the
// key-input PIO and its per-bit debouncer.
package nios_system_key_in_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [1:0] ADDR_RESERVED = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Qualifies an accepted level change; level is the value being accepted.
    function automatic logic edge_event(input int edge_type, input logic upd, input logic level);
        case (edge_type)
            EDGE_RISING:  return upd & level;
            EDGE_FALLING: return upd & ~level;
            default:      return upd;
        endcase
    endfunction

endpackage

// File: rtl/nios_system_key_debounce.sv
// One key bit: two-flop synchroniser, stability counter and accepted level.
// upd_o pulses on the cycle the new level is taken into stable_o.
module nios_system_key_debounce #(
    parameter int   DB_CYCLES   = 50000,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic sync2_o,
    output logic stable_o,
    output logic upd_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q, stable_q, stable_d;
    logic [CW-1:0] count_q, count_d;
    logic          differ;

    assign differ = (sync2_q != stable_q);
    assign upd_o  = differ && (count_q == TC);

    always_comb begin
        stable_d = stable_q;
        count_d  = '0;
        if (upd_o) begin
            stable_d = sync2_q;
        end else if (differ) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            count_q  <= '0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    assign sync2_o  = sync2_q;
    assign stable_o = stable_q;
endmodule

// File: rtl/nios_system_key_in.sv
// Avalon-MM push-button PIO: debounced key levels, W1C edge capture and a
// maskable level interrupt, with zero-wait-state combinational reads.
module nios_system_key_in
    import nios_system_key_in_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               DB_CYCLES   = 50000,
    parameter int               EDGE_TYPE   = EDGE_FALLING,
    parameter logic [WIDTH-1:0] RESET_LEVEL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync2, stable, upd, edge_evt;
    logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d, clr_bits;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        nios_system_key_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .RESET_LEVEL (RESET_LEVEL[i])
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .key_i    (in_port[i]),
            .sync2_o  (sync2[i]),
            .stable_o (stable[i]),
            .upd_o    (upd[i])
        );
        assign edge_evt[i] = edge_event(EDGE_TYPE, upd[i], sync2[i]);
    end

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // Set wins over a same-cycle clear so a fresh edge is never lost.
    always_comb begin
        clr_bits  = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        edgecap_d = (edgecap_q & ~clr_bits) | edge_evt;
        irqmask_d = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = stable;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_nios_system_key_in.sv
// Directed and random checks of the key PIO (falling-edge and any-edge
// instances) against a window-based reference model.
module tb_nios_system_key_in;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_f, rd_a;
    logic        irq_f, irq_a;

    int checks = 0;
    int failures = 0;
    int lat;

    logic [3:0] m_s1, m_s2, m_stable, m_mask, m_ec_f, m_ec_a;
    logic [3:0] hist[$];

    always #5 clk = ~clk;

    nios_system_key_in #(.WIDTH(4), .DB_CYCLES(DB), .EDGE_TYPE(1), .RESET_LEVEL(4'hF)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f));

    nios_system_key_in #(.WIDTH(4), .DB_CYCLES(DB), .EDGE_TYPE(2), .RESET_LEVEL(4'hF)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_stable = 4'hF;
        m_mask = 4'h0; m_ec_f = 4'h0; m_ec_a = 4'h0;
        hist.delete();
        for (int j = 0; j < DB; j++) hist.push_back(4'hF);
    endtask

    // A bit is accepted once its last DB synchronised samples all differ from
    // the accepted level; the sample seen at an edge is the input two edges old.
    task automatic model_step();
        logic [3:0] cur, upd, clr;
        logic       all_diff;
        cur = m_s2;
        hist.push_back(cur);
        if (hist.size() > DB) void'(hist.pop_front());
        upd = 4'h0;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            foreach (hist[j]) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
            upd[i] = all_diff;
        end
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_ec_f = (m_ec_f & ~clr) | (upd & ~cur);
        m_ec_a = (m_ec_a & ~clr) | upd;
        if (chipselect && !write_n && address == 2'd1) m_mask = writedata[3:0];
        m_stable = m_stable ^ upd;
        m_s2 = m_s1;
        m_s1 = in_port;
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [3:0] ec);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'(m_mask);
            2'd3:    return 32'(ec);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_now();
        chk("rd_fall", rd_f, exp_rd(address, m_ec_f));
        chk("rd_any", rd_a, exp_rd(address, m_ec_a));
        chk("irq_fall", 32'(irq_f), 32'(|(m_ec_f & m_mask)));
        chk("irq_any", 32'(irq_a), 32'(|(m_ec_a & m_mask)));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        check_now();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic idle();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cycle();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_port = 4'hF; address = 2'd0; idle();
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("reset_data", rd_f, 32'hF);
        address = 2'd3; #1;
        chk("reset_edgecap", rd_f, 32'h0);
        chk("reset_irq", 32'(irq_f), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(8);
        chk("no_edge_after_reset", rd_f, 32'h0);

        bus_write(2'd1, 32'h1);

        // Key 0 press: measure latency from input change to DATA change.
        address = 2'd0;
        in_port[0] = 1'b0;
        lat = 99;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (rd_f[0] == 1'b0) begin lat = n; break; end
        end
        chk("latency_in_range", 32'(lat >= 5 && lat <= 7), 32'h1);
        chk("irq_with_data", 32'(irq_f), 32'h1);
        cycles(4);

        // Glitch of 3 cycles on key 1 must be rejected.
        in_port[1] = 1'b0; cycles(3);
        in_port[1] = 1'b1; cycles(10);
        chk("glitch_data", rd_f, 32'hE);
        address = 2'd3; #1;
        chk("glitch_edgecap", rd_f, 32'h1);

        bus_write(2'd3, 32'h0);
        chk("w1c_zero_keeps", rd_f, 32'h1);
        chk("irq_set", 32'(irq_f), 32'h1);
        bus_write(2'd3, 32'h1);
        chk("w1c_clears", rd_f, 32'h0);
        chk("irq_cleared", 32'(irq_f), 32'h0);

        // Key 2 press with a clear landing on the acceptance edge.
        in_port[2] = 1'b0;
        cycles(5);
        bus_write(2'd3, 32'h4);
        chk("set_wins_over_clear", rd_f & 32'h4, 32'h4);

        // Any-edge instance: press and release key 3.
        bus_write(2'd3, 32'hF);
        in_port[3] = 1'b0; cycles(10);
        chk("any_press", rd_a & 32'h8, 32'h8);
        chk("fall_press", rd_f & 32'h8, 32'h8);
        bus_write(2'd3, 32'hF);
        in_port[3] = 1'b1; cycles(10);
        chk("any_release", rd_a & 32'h8, 32'h8);
        chk("fall_release", rd_f & 32'h8, 32'h0);
        bus_write(2'd2, 32'hFFFF_FFFF);
        address = 2'd2; #1;
        chk("reserved_reads_0", rd_f, 32'h0);

        // Reset in the middle of a debounce count.
        bus_write(2'd3, 32'hF);
        in_port = 4'hF; cycles(3);
        reset_n = 1'b0; model_reset(); #1;
        check_now();
        @(negedge clk);
        reset_n = 1'b1;
        address = 2'd3;
        cycles(10);
        chk("midcount_reset_fall", rd_f, 32'h0);
        chk("midcount_reset_any", rd_a, 32'h0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) in_port[i] = ~in_port[i];
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0; model_reset();
            end else begin
                reset_n = 1'b1;
            end
            cycle();
        end
        reset_n = 1'b1;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
